sim_io_ctrl: RTL and testbench
==============================

Name: sim_io_ctrl

Overview:
- Parametrised memory-mapped test I/O peripheral for the cpu4510 bench. It generalises the single-byte irq/nmi port.
- Provides NUM_PORTS general byte ports, a 16-bit down-counter timer that can raise irq or nmi, and a programmable ready-stall generator.
- Provides an exit register that ends simulation runs.
- Decodes on the CPU's next-cycle address bus, alongside memory and hyper_ctrl, and feeds the bench read mux.

Parameters:
- BASE_ADDR, 20'h0BFF0, base of the 16-byte register window; low 4 bits must be 0.
- NUM_PORTS, 4, number of general byte ports at offsets 0..NUM_PORTS-1; range 1..8.
- LFSR_SEED, 16'hACE1, reset seed of the random-ready LFSR; must be non-zero.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high reset.
- address_next  in  20  CPU next-cycle address.
- write_next  in  1  CPU next-cycle write strobe.
- data_i  in  8  CPU write data, valid with write_next.
- cs  out  1  combinational: address_next[19:4] == BASE_ADDR[19:4].
- data_o  out  8  registered read data, valid the cycle after cs.
- ready  out  1  registered bus-ready to the CPU and the memory write gate.
- irq  out  1  level interrupt request.
- nmi  out  1  non-maskable interrupt line.
- ports_o  out  8*NUM_PORTS  all port register contents; port n is bits [8n+7:8n].
- done  out  1  sticky; set by a write to EXIT.
- exit_code  out  8  value written to EXIT.

Behaviour:
- Write acceptance:
  - A write is accepted when cs & write_next & ready, at the posedge.
  - Writes while ready=0 are ignored entirely.
- Read path:
  - data_o <= the register at address_next[3:0] whenever cs, independent of ready.
  - Unmapped offsets read 8'h00.
  - data_o holds its value when cs=0.
- Register map (offset: function):
  - 0..NUM_PORTS-1: PORTn, read/write.
  - 8: TIMER_LO, latched only.
  - 9: TIMER_HI. A write loads count={data_i,TIMER_LO}, copies the same value to reload, and sets running=1.
  - A: CTRL.
    - bit0 tmr_en.
    - bit1 tmr_nmi (route the timer to nmi instead of irq).
    - bit2 autoreload.
    - bits[5:4] rdy_mode.
  - B: STATUS.
    - bit0 tmr_flag; write-1-to-clear.
    - bit1 running; read-only.
  - C: STALL, 8-bit.
  - F: EXIT. A write sets done=1 and exit_code=data_i; a later write updates exit_code.
- irq = PORT0[0] | (tmr_flag & tmr_en & ~tmr_nmi).
- nmi = PORT0[1] | (tmr_flag & tmr_en & tmr_nmi).
- Both irq and nmi are combinational from registers.
- Timer:
  - While running, count decrements by 1 each cycle.
  - On the cycle count transitions 1->0, tmr_flag<=1.
  - At that point, if autoreload, count<=reload and running stays 1; otherwise running<=0.
  - Loading 0: tmr_flag sets on the next cycle, then the autoreload rule applies (reload=0 with autoreload flags every cycle).
  - A flag set and a W1C clear in the same cycle: set wins.
  - A TIMER_HI write while running restarts the timer with the new value.
- Ready generator, by rdy_mode:
  - 00: ready=1.
  - 01: ready toggles every cycle, first cycle after reset is 1.
  - 10: ready=lfsr[0], with a Galois LFSR x^16+x^14+x^13+x^11+1 advancing every cycle. A guard counter forces ready=1 after 3 consecutive low cycles.
  - 11: repeating pattern of STALL cycles low then 1 cycle high; STALL=0 means constant 1.
  - A CTRL write changes the mode; the new pattern starts the following cycle, and the phase and stall counters restart.
- Reset values (all take effect on the posedge with reset=1):
  - ports 0, count 0, reload 0, running 0, tmr_flag 0.
  - CTRL 0, STALL 0, lfsr LFSR_SEED.
  - data_o 0, ready 1, done 0, exit_code 0, irq 0, nmi 0.
- Reset mid-countdown aborts the timer with no flag.

Decomposition:
- Shared package sim_io_pkg holds:
  - register offset constants (OFS_TIMER_LO=8 .. OFS_EXIT=15);
  - CTRL bit indices;
  - rdy_mode encodings (RDY_ALWAYS, RDY_ALT, RDY_RAND, RDY_STALL);
  - the LFSR tap mask.
- One sub-module: sim_ready_gen, covering mode, STALL, the LFSR, the guard counter and the registered ready.
- Decode, registers and timer stay in the top level.

Test Plan:
- Reset, then write PORT0=8'h01 -> irq=1 from the next cycle and nmi=0; write PORT0=8'h00 -> irq=0; read PORT0 -> data_o=8'h00 one cycle after cs.
- CTRL=8'h01, TIMER_LO=8'h05, TIMER_HI=8'h00 -> tmr_flag and irq rise exactly 5 cycles after the HI write and running=0; STATUS W1C 8'h01 -> irq falls the next cycle.
- CTRL=8'h07, timer load 3 -> nmi asserted every 3rd cycle boundary (flag re-sets); a W1C issued on the reload cycle leaves the flag set.
- CTRL=8'h30, STALL=2 -> ready pattern 0,0,1 repeating; a write issued while ready=0 leaves the target register unchanged.
- CTRL=8'h20 -> 1000 cycles: never 4 consecutive ready=0, sequence matches the LFSR model seeded 16'hACE1.
- Write EXIT=8'h5A -> done=1 and exit_code=8'h5A next cycle; assert reset -> done=0, ready=1, all ports 0.

Source files
------------

// File: rtl/sim_io_pkg.sv
// Shared constants for the sim_io_ctrl test peripheral: register offsets, CTRL bit
// positions, ready-generator modes and the LFSR used for random bus stalls.
package sim_io_pkg;

  localparam logic [3:0] OFS_TIMER_LO = 4'h8;
  localparam logic [3:0] OFS_TIMER_HI = 4'h9;
  localparam logic [3:0] OFS_CTRL     = 4'hA;
  localparam logic [3:0] OFS_STATUS   = 4'hB;
  localparam logic [3:0] OFS_STALL    = 4'hC;
  localparam logic [3:0] OFS_EXIT     = 4'hF;

  localparam int unsigned CTRL_TMR_EN     = 0;
  localparam int unsigned CTRL_TMR_NMI    = 1;
  localparam int unsigned CTRL_AUTORELOAD = 2;
  localparam int unsigned CTRL_RDY_LSB    = 4;

  typedef enum logic [1:0] {
    RDY_ALWAYS = 2'b00,
    RDY_ALT    = 2'b01,
    RDY_RAND   = 2'b10,
    RDY_STALL  = 2'b11
  } rdy_mode_e;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    lfsr_step = {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/sim_ready_gen.sv
// Registered bus-ready generator: constant, alternating, LFSR-random with a low-run
// guard, or a programmable stall pattern.
module sim_ready_gen
  import sim_io_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  rdy_mode_e  mode_i,
  input  logic       restart_i,
  input  rdy_mode_e  new_mode_i,
  input  logic [7:0] stall_i,
  output logic       ready_o
);

  rdy_mode_e   mode_eff;
  logic [7:0]  stall_cnt_q, stall_cnt_d, stall_cnt_eff;
  logic [1:0]  low_cnt_q, low_cnt_d, low_cnt_eff;
  logic [15:0] lfsr_q, lfsr_d;
  logic        ready_q, ready_d;

  // A CTRL write applies the new mode immediately so its first value shows next cycle.
  always_comb begin
    mode_eff      = restart_i ? new_mode_i : mode_i;
    stall_cnt_eff = restart_i ? 8'd0 : stall_cnt_q;
    low_cnt_eff   = restart_i ? 2'd0 : low_cnt_q;
    lfsr_d        = lfsr_q;
    stall_cnt_d   = 8'd0;
    low_cnt_d     = 2'd0;
    ready_d       = 1'b1;
    unique case (mode_eff)
      RDY_ALWAYS: ready_d = 1'b1;
      RDY_ALT:    ready_d = restart_i ? 1'b1 : ~ready_q;
      RDY_RAND: begin
        lfsr_d    = lfsr_step(lfsr_q);
        ready_d   = lfsr_d[0] | (low_cnt_eff == 2'd3);
        low_cnt_d = ready_d ? 2'd0 : low_cnt_eff + 2'd1;
      end
      RDY_STALL: begin
        ready_d     = (stall_cnt_eff >= stall_i);
        stall_cnt_d = ready_d ? 8'd0 : stall_cnt_eff + 8'd1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cnt_q <= 8'd0;
      low_cnt_q   <= 2'd0;
      lfsr_q      <= LFSR_SEED;
      ready_q     <= 1'b1;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      low_cnt_q   <= low_cnt_d;
      lfsr_q      <= lfsr_d;
      ready_q     <= ready_d;
    end
  end

  assign ready_o = ready_q;

endmodule

// File: rtl/sim_io_ctrl.sv
// Memory-mapped test I/O block: byte ports, interrupt timer, ready-stall generator and
// simulation exit register, decoded on the CPU next-cycle address bus.
module sim_io_ctrl
  import sim_io_pkg::*;
#(
  parameter logic [19:0] BASE_ADDR = 20'h0BFF0,
  parameter int unsigned NUM_PORTS = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [19:0]            address_next,
  input  logic                   write_next,
  input  logic [7:0]             data_i,
  output logic                   cs,
  output logic [7:0]             data_o,
  output logic                   ready,
  output logic                   irq,
  output logic                   nmi,
  output logic [8*NUM_PORTS-1:0] ports_o,
  output logic                   done,
  output logic [7:0]             exit_code
);

  logic [7:0]  port_q [NUM_PORTS];
  logic [7:0]  timer_lo_q, stall_q, data_o_q, exit_code_q, rdata;
  logic [15:0] count_q, count_d, reload_q, reload_d;
  logic        running_q, running_d, tmr_flag_q, tmr_flag_d, timer_set;
  logic        tmr_en_q, tmr_nmi_q, autoreload_q, done_q;
  rdy_mode_e   rdy_mode_q;
  logic [3:0]  ofs;
  logic        we;

  assign cs  = (address_next[19:4] == BASE_ADDR[19:4]);
  assign ofs = address_next[3:0];
  assign we  = cs & write_next & ready;

  always_comb begin
    rdata = 8'h00;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (ofs == 4'(i)) rdata = port_q[i];
    end
    case (ofs)
      OFS_TIMER_LO: rdata = timer_lo_q;
      OFS_TIMER_HI: rdata = count_q[15:8];
      OFS_CTRL:     rdata = {2'b00, rdy_mode_q, 1'b0, autoreload_q, tmr_nmi_q, tmr_en_q};
      OFS_STATUS:   rdata = {6'b0, running_q, tmr_flag_q};
      OFS_STALL:    rdata = stall_q;
      OFS_EXIT:     rdata = exit_code_q;
      default:      ;
    endcase
  end

  // Count of 0 or 1 both expire on this edge, so a zero load flags one cycle later.
  always_comb begin
    count_d   = count_q;
    reload_d  = reload_q;
    running_d = running_q;
    timer_set = 1'b0;
    if (running_q) begin
      if (count_q <= 16'd1) begin
        timer_set = 1'b1;
        if (autoreload_q) begin
          count_d = reload_q;
        end else begin
          count_d   = 16'd0;
          running_d = 1'b0;
        end
      end else begin
        count_d = count_q - 16'd1;
      end
    end
    if (we && ofs == OFS_TIMER_HI) begin
      count_d   = {data_i, timer_lo_q};
      reload_d  = {data_i, timer_lo_q};
      running_d = 1'b1;
    end
    tmr_flag_d = tmr_flag_q;
    if (we && ofs == OFS_STATUS && data_i[0]) tmr_flag_d = 1'b0;
    if (timer_set) tmr_flag_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) port_q[i] <= 8'h00;
      timer_lo_q   <= 8'h00;
      count_q      <= 16'd0;
      reload_q     <= 16'd0;
      running_q    <= 1'b0;
      tmr_flag_q   <= 1'b0;
      tmr_en_q     <= 1'b0;
      tmr_nmi_q    <= 1'b0;
      autoreload_q <= 1'b0;
      rdy_mode_q   <= RDY_ALWAYS;
      stall_q      <= 8'h00;
      data_o_q     <= 8'h00;
      done_q       <= 1'b0;
      exit_code_q  <= 8'h00;
    end else begin
      count_q    <= count_d;
      reload_q   <= reload_d;
      running_q  <= running_d;
      tmr_flag_q <= tmr_flag_d;
      if (cs) data_o_q <= rdata;
      if (we) begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
          if (ofs == 4'(i)) port_q[i] <= data_i;
        end
        case (ofs)
          OFS_TIMER_LO: timer_lo_q <= data_i;
          OFS_CTRL: begin
            tmr_en_q     <= data_i[CTRL_TMR_EN];
            tmr_nmi_q    <= data_i[CTRL_TMR_NMI];
            autoreload_q <= data_i[CTRL_AUTORELOAD];
            rdy_mode_q   <= rdy_mode_e'(data_i[CTRL_RDY_LSB +: 2]);
          end
          OFS_STALL: stall_q <= data_i;
          OFS_EXIT: begin
            done_q      <= 1'b1;
            exit_code_q <= data_i;
          end
          default: ;
        endcase
      end
    end
  end

  sim_ready_gen #(
    .LFSR_SEED(LFSR_SEED)
  ) u_ready_gen (
    .clk_i      (clk),
    .reset_i    (reset),
    .mode_i     (rdy_mode_q),
    .restart_i  (we && ofs == OFS_CTRL),
    .new_mode_i (rdy_mode_e'(data_i[CTRL_RDY_LSB +: 2])),
    .stall_i    (stall_q),
    .ready_o    (ready)
  );

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_ports
    assign ports_o[8*g +: 8] = port_q[g];
  end

  assign irq       = port_q[0][0] | (tmr_flag_q & tmr_en_q & ~tmr_nmi_q);
  assign nmi       = port_q[0][1] | (tmr_flag_q & tmr_en_q & tmr_nmi_q);
  assign data_o    = data_o_q;
  assign done      = done_q;
  assign exit_code = exit_code_q;

endmodule

// File: tb/tb_sim_io_ctrl.sv
// Scoreboard bench for sim_io_ctrl: stimulus queues timed expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_sim_io_ctrl;

  localparam int unsigned NP   = 4;
  localparam logic [19:0] BASE = 20'h0BFF0;
  localparam logic [19:0] IDLE = 20'h00000;

  logic            clk = 1'b0;
  logic            reset;
  logic [19:0]     address_next;
  logic            write_next;
  logic [7:0]      data_i;
  logic            cs;
  logic [7:0]      data_o;
  logic            ready;
  logic            irq;
  logic            nmi;
  logic [8*NP-1:0] ports_o;
  logic            done;
  logic [7:0]      exit_code;

  sim_io_ctrl #(
    .BASE_ADDR(BASE),
    .NUM_PORTS(NP),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .address_next(address_next),
    .write_next  (write_next),
    .data_i      (data_i),
    .cs          (cs),
    .data_o      (data_o),
    .ready       (ready),
    .irq         (irq),
    .nmi         (nmi),
    .ports_o     (ports_o),
    .done        (done),
    .exit_code   (exit_code)
  );

  always #5 clk = ~clk;

  typedef enum {S_IRQ, S_NMI, S_DATA, S_READY, S_DONE, S_EXIT, S_PORTS, S_CS} sig_e;
  typedef struct {
    int unsigned at;
    sig_e        sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int unsigned rand_lo = 32'hFFFF_FFFF;
  int unsigned rand_hi = 0;
  int          run = 0;
  int          max_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(input sig_e s);
    case (s)
      S_IRQ:   sample = {31'b0, irq};
      S_NMI:   sample = {31'b0, nmi};
      S_DATA:  sample = {24'b0, data_o};
      S_READY: sample = {31'b0, ready};
      S_DONE:  sample = {31'b0, done};
      S_EXIT:  sample = {24'b0, exit_code};
      S_PORTS: sample = ports_o;
      default: sample = {31'b0, cs};
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t        it;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      it  = sb.pop_front();
      act = sample(it.sel);
      checks++;
      if (it.at != cyc || act !== it.exp) begin
        errors++;
        $display("FAIL %s cycle %0d (due %0d): got %h expected %h", it.name, cyc, it.at, act,
                 it.exp);
      end
    end
    if (cyc >= rand_lo && cyc <= rand_hi) begin
      if (!ready) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
  end

  task automatic expect_at(input int unsigned at, input sig_e sel, input logic [31:0] v,
                           input string nm);
    exp_t it;
    int   i;
    it.at   = at;
    it.sel  = sel;
    it.exp  = v;
    it.name = nm;
    i = 0;
    while (i < sb.size() && sb[i].at <= at) i++;
    sb.insert(i, it);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int unsigned t);
    while (cyc < t) tick(1);
  endtask

  task automatic wr(input logic [3:0] ofs, input logic [7:0] d, input bit wait_rdy,
                    output int unsigned e);
    int n;
    n = 0;
    if (wait_rdy) begin
      while (!ready && n < 64) begin
        tick(1);
        n++;
      end
      if (n >= 64) begin
        checks++;
        errors++;
        $display("FAIL wr_ready_timeout ofs %h: got ready=0 for 64 cycles, expected ready=1",
                 ofs);
      end
    end
    address_next = {BASE[19:4], ofs};
    write_next   = 1'b1;
    data_i       = d;
    e            = cyc + 1;
    tick(1);
    write_next   = 1'b0;
    address_next = IDLE;
  endtask

  task automatic rd(input logic [3:0] ofs, input logic [7:0] v, input string nm);
    address_next = {BASE[19:4], ofs};
    write_next   = 1'b0;
    expect_at(cyc, S_CS, 32'd1, {nm, "_cs"});
    expect_at(cyc + 1, S_DATA, {24'b0, v}, nm);
    tick(1);
    address_next = IDLE;
  endtask

  task automatic do_reset(input string nm);
    int unsigned e;
    reset = 1'b1;
    e     = cyc + 1;
    tick(1);
    reset = 1'b0;
    expect_at(e, S_READY, 32'd1, {nm, "_ready"});
    expect_at(e, S_IRQ,   32'd0, {nm, "_irq"});
    expect_at(e, S_NMI,   32'd0, {nm, "_nmi"});
    expect_at(e, S_DONE,  32'd0, {nm, "_done"});
    expect_at(e, S_EXIT,  32'd0, {nm, "_exit"});
    expect_at(e, S_PORTS, 32'd0, {nm, "_ports"});
    expect_at(e, S_DATA,  32'd0, {nm, "_data"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned e, h, s, r;
    logic [15:0] lf;
    logic        lsb, rdy;
    int          low;

    reset        = 1'b1;
    address_next = IDLE;
    write_next   = 1'b0;
    data_i       = 8'h00;
    do_reset("reset");

    // Port 0 drives irq/nmi directly.
    wr(4'h0, 8'h01, 1'b1, e);
    expect_at(e, S_IRQ, 32'd1, "port0_irq_set");
    expect_at(e, S_NMI, 32'd0, "port0_nmi_clear");
    expect_at(e, S_PORTS, 32'h0000_0001, "port0_value");
    wr(4'h0, 8'h00, 1'b1, e);
    expect_at(e, S_IRQ, 32'd0, "port0_irq_clear");
    rd(4'h0, 8'h00, "rd_port0");

    // One-shot timer of 5 routed to irq.
    wr(4'hA, 8'h01, 1'b1, e);
    wr(4'h8, 8'h05, 1'b1, e);
    wr(4'h9, 8'h00, 1'b1, h);
    expect_at(h + 4, S_IRQ, 32'd0, "tmr5_irq_early");
    expect_at(h + 5, S_IRQ, 32'd1, "tmr5_irq_fire");
    wait_until(h + 5);
    rd(4'hB, 8'h01, "tmr5_status");
    wr(4'hB, 8'h01, 1'b1, e);
    expect_at(e, S_IRQ, 32'd0, "tmr5_w1c");

    // Autoreload timer of 3 routed to nmi; W1C on a reload edge loses to the set.
    wr(4'hA, 8'h07, 1'b1, e);
    wr(4'h8, 8'h03, 1'b1, e);
    wr(4'h9, 8'h00, 1'b1, h);
    expect_at(h + 2, S_NMI, 32'd0, "ar_nmi_before");
    expect_at(h + 3, S_NMI, 32'd1, "ar_nmi_first");
    expect_at(h + 3, S_IRQ, 32'd0, "ar_irq_quiet");
    expect_at(h + 4, S_NMI, 32'd0, "ar_nmi_cleared");
    expect_at(h + 5, S_NMI, 32'd0, "ar_nmi_still_clear");
    expect_at(h + 6, S_NMI, 32'd1, "ar_nmi_second");
    expect_at(h + 9, S_NMI, 32'd1, "ar_set_wins");
    expect_at(h + 10, S_NMI, 32'd1, "ar_set_held");
    wait_until(h + 3);
    wr(4'hB, 8'h01, 1'b1, e);
    wait_until(h + 8);
    wr(4'hB, 8'h01, 1'b1, e);
    wait_until(h + 10);
    wr(4'hA, 8'h00, 1'b1, e);

    // Stall mode, 2 low then 1 high.
    wr(4'hC, 8'h02, 1'b1, e);
    wr(4'hA, 8'h30, 1'b1, s);
    expect_at(s,     S_READY, 32'd0, "stall_p0");
    expect_at(s + 1, S_READY, 32'd0, "stall_p1");
    expect_at(s + 2, S_READY, 32'd1, "stall_p2");
    expect_at(s + 3, S_READY, 32'd0, "stall_p3");
    expect_at(s + 4, S_READY, 32'd0, "stall_p4");
    expect_at(s + 5, S_READY, 32'd1, "stall_p5");
    wait_until(s + 3);
    wr(4'h1, 8'hEE, 1'b0, e);
    expect_at(e, S_PORTS, 32'h0000_0000, "stall_write_ignored");
    expect_at(e + 1, S_PORTS, 32'h0000_0000, "stall_write_ignored_hold");
    wr(4'h1, 8'h77, 1'b1, e);
    expect_at(e, S_PORTS, 32'h0000_7700, "stall_write_accepted");

    // Random ready against an independent LFSR model.
    do_reset("reset2");
    wr(4'hA, 8'h20, 1'b1, r);
    rand_lo = r;
    rand_hi = r + 999;
    lf  = 16'hACE1;
    low = 0;
    for (int k = 0; k < 1000; k++) begin
      lsb = lf[0];
      lf  = lf >> 1;
      if (lsb) lf = lf ^ 16'hB400;
      rdy = lf[0] | (low == 3);
      low = rdy ? 0 : low + 1;
      expect_at(r + k, S_READY, {31'b0, rdy}, $sformatf("rand_rdy_%0d", k));
    end
    wait_until(r + 1000);
    checks++;
    if (max_run >= 4) begin
      errors++;
      $display("FAIL rand_max_low_run: got %0d expected at most 3", max_run);
    end

    // Exit register and final reset.
    wr(4'h2, 8'hA5, 1'b1, e);
    expect_at(e, S_PORTS, 32'h00A5_0000, "port2_value");
    expect_at(cyc, S_DONE, 32'd0, "done_before_exit");
    wr(4'hF, 8'h5A, 1'b1, e);
    expect_at(e, S_DONE, 32'd1, "exit_done");
    expect_at(e, S_EXIT, 32'h5A, "exit_code");
    wr(4'hF, 8'h33, 1'b1, e);
    expect_at(e, S_DONE, 32'd1, "exit_done_sticky");
    expect_at(e, S_EXIT, 32'h33, "exit_code_update");
    tick(1);
    do_reset("reset3");
    tick(3);

    while (sb.size() > 0) begin
      exp_t it;
      it = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s never compared: got no sample expected %h at cycle %0d", it.name,
               it.exp, it.at);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
